// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one single-port SRAM between an instruction-fetch requester and a
// data-memory requester. Grants are combinational and the granted access is
// driven onto the SRAM pins in the same cycle. Read data comes back one cycle
// later and is steered by a registered in-flight tag.
//
// Ports
//   clk, rst                  clock, async active-low reset
//   fetch_req_valid/addr      fetch read request (byte address, word [15:2])
//   fetch_flush               kills a pending fetch and its in-flight response
//   fetch_req_ready           fetch granted this cycle
//   fetch_rsp_valid/data      fetch read response (data always mirrors DO)
//   dm_req_valid/we/wstrb/
//   dm_addr/dm_wdata          data-memory request
//   dm_req_ready              data request granted this cycle
//   dm_rsp_valid/data         data read response (data always mirrors DO)
//   CEB/WEB/BWEB/A/DI         SRAM control, all active-low enables
//   DO                        SRAM read data, one cycle after a read
//
// Tag FSM
//   state     | meaning
//   TAG_NONE  | no read in flight, no response this cycle
//   TAG_FETCH | a fetch read was issued last cycle
//   TAG_DM    | a data read was issued last cycle
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_req_valid,
    input  logic [31:0] fetch_addr,
    input  logic        fetch_flush,
    output logic        fetch_req_ready,
    output logic        fetch_rsp_valid,
    output logic [31:0] fetch_rsp_data,
    input  logic        dm_req_valid,
    input  logic        dm_we,
    input  logic [3:0]  dm_wstrb,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_req_ready,
    output logic        dm_rsp_valid,
    output logic [31:0] dm_rsp_data,
    output logic        CEB,
    output logic        WEB,
    output logic [31:0] BWEB,
    output logic [13:0] A,
    output logic [31:0] DI,
    input  logic [31:0] DO
);

    typedef enum logic [1:0] {
        TAG_NONE  = 2'd0,
        TAG_FETCH = 2'd1,
        TAG_DM    = 2'd2
    } tag_t;

    localparam logic [3:0] LP_STARVE_MAX = 4'(STARVE_MAX);

    tag_t       r_tag;
    tag_t       w_tag_nxt;
    logic [3:0] r_starve_cnt;
    logic [3:0] w_starve_nxt;
    logic       w_fetch_elig;
    logic       w_dm_elig;
    logic       w_fetch_win;
    logic       w_dm_win;
    logic       w_unused;

    // Address bits outside the 64 KiB word window are intentionally ignored.
    assign w_unused = ^{fetch_addr[31:16], fetch_addr[1:0],
                        dm_addr[31:16], dm_addr[1:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tag        <= TAG_NONE;
            r_starve_cnt <= '0;
        end else begin
            r_tag        <= w_tag_nxt;
            r_starve_cnt <= w_starve_nxt;
        end
    end

    always_comb begin
        w_tag_nxt       = TAG_NONE;
        w_starve_nxt    = '0;
        fetch_req_ready = 1'b0;
        dm_req_ready    = 1'b0;
        CEB             = 1'b1;
        WEB             = 1'b1;
        BWEB            = '1;
        A               = '0;
        DI              = '0;

        // Grants are gated by rst so nothing is issued while reset is held.
        w_fetch_elig = rst & fetch_req_valid & ~fetch_flush;
        w_dm_elig    = rst & dm_req_valid;
        w_fetch_win  = w_fetch_elig &
                       (~w_dm_elig | (r_starve_cnt == LP_STARVE_MAX));
        w_dm_win     = w_dm_elig & ~w_fetch_win;

        if (w_fetch_elig && !w_fetch_win) begin
            w_starve_nxt = (r_starve_cnt == LP_STARVE_MAX) ? r_starve_cnt
                                                           : r_starve_cnt + 4'd1;
        end

        if (w_fetch_win) begin
            fetch_req_ready = 1'b1;
            CEB             = 1'b0;
            A               = fetch_addr[15:2];
            w_tag_nxt       = TAG_FETCH;
        end else if (w_dm_win) begin
            dm_req_ready = 1'b1;
            CEB          = 1'b0;
            A            = dm_addr[15:2];
            if (dm_we) begin
                // An all-zero strobe is granted but leaves the SRAM in read
                // mode; the tag stays NONE so no response is produced.
                WEB = ~|dm_wstrb;
                DI  = dm_wdata;
                for (int i = 0; i < 4; i++) begin
                    BWEB[8*i +: 8] = dm_wstrb[i] ? 8'h00 : 8'hFF;
                end
            end else begin
                w_tag_nxt = TAG_DM;
            end
        end
    end

    assign fetch_rsp_valid = (r_tag == TAG_FETCH) && !fetch_flush;
    assign dm_rsp_valid    = (r_tag == TAG_DM);
    assign fetch_rsp_data  = DO;
    assign dm_rsp_data     = DO;

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int STARVE_MAX = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_req_valid;
    logic [31:0] fetch_addr;
    logic        fetch_flush;
    logic        fetch_req_ready;
    logic        fetch_rsp_valid;
    logic [31:0] fetch_rsp_data;
    logic        dm_req_valid;
    logic        dm_we;
    logic [3:0]  dm_wstrb;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_req_ready;
    logic        dm_rsp_valid;
    logic [31:0] dm_rsp_data;
    logic        CEB;
    logic        WEB;
    logic [31:0] BWEB;
    logic [13:0] A;
    logic [31:0] DI;
    logic [31:0] DO = 32'h0;

    int checks   = 0;
    int failures = 0;

    mem_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
        .clk             (clk),
        .rst             (rst),
        .fetch_req_valid (fetch_req_valid),
        .fetch_addr      (fetch_addr),
        .fetch_flush     (fetch_flush),
        .fetch_req_ready (fetch_req_ready),
        .fetch_rsp_valid (fetch_rsp_valid),
        .fetch_rsp_data  (fetch_rsp_data),
        .dm_req_valid    (dm_req_valid),
        .dm_we           (dm_we),
        .dm_wstrb        (dm_wstrb),
        .dm_addr         (dm_addr),
        .dm_wdata        (dm_wdata),
        .dm_req_ready    (dm_req_ready),
        .dm_rsp_valid    (dm_rsp_valid),
        .dm_rsp_data     (dm_rsp_data),
        .CEB             (CEB),
        .WEB             (WEB),
        .BWEB            (BWEB),
        .A               (A),
        .DI              (DI),
        .DO              (DO)
    );

    always #5 clk = ~clk;

    // SRAM behavioural model seen by the DUT
    logic [31:0] sram [256];
    always @(posedge clk) begin
        if (!CEB) begin
            if (!WEB) sram[A[7:0]] <= (sram[A[7:0]] & BWEB) | (DI & ~BWEB);
            else      DO <= sram[A[7:0]];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h time=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: arbitration rules, starvation count, expected memory
    // contents and the read awaiting its response, all at transaction level.
    logic [31:0] smem [256];
    int          m_starve = 0;
    int          m_last   = 0;   // 0 none, 1 fetch, 2 dm
    logic [31:0] m_data   = 32'h0;

    always @(negedge clk) begin
        logic        f_ok, d_ok, gf, gd, wr;
        logic [31:0] e_bweb, e_di, mask;
        logic [13:0] e_a;
        if (!rst) begin
            check("rst_fetch_ready", 32'(fetch_req_ready), 32'd0);
            check("rst_dm_ready",    32'(dm_req_ready),    32'd0);
            check("rst_fetch_rsp_v", 32'(fetch_rsp_valid), 32'd0);
            check("rst_dm_rsp_v",    32'(dm_rsp_valid),    32'd0);
            check("rst_CEB",  32'(CEB), 32'd1);
            check("rst_WEB",  32'(WEB), 32'd1);
            check("rst_BWEB", BWEB, 32'hFFFF_FFFF);
            check("rst_A",    32'(A), 32'd0);
            check("rst_DI",   DI, 32'd0);
            m_starve = 0;
            m_last   = 0;
        end else begin
            f_ok = fetch_req_valid && !fetch_flush;
            d_ok = dm_req_valid;
            gf   = f_ok && (!d_ok || m_starve == STARVE_MAX);
            gd   = d_ok && !gf;
            wr   = gd && dm_we;
            e_bweb = 32'hFFFF_FFFF;
            e_di   = 32'h0;
            e_a    = 14'h0;
            if (gf) e_a = fetch_addr[15:2];
            if (gd) e_a = dm_addr[15:2];
            if (wr) begin
                e_di = dm_wdata;
                for (int b = 0; b < 4; b++)
                    if (dm_wstrb[b]) e_bweb[8*b +: 8] = 8'h00;
            end
            check("fetch_ready", 32'(fetch_req_ready), 32'(gf));
            check("dm_ready",    32'(dm_req_ready),    32'(gd));
            check("CEB",  32'(CEB), 32'(!(gf || gd)));
            check("WEB",  32'(WEB), 32'(!(wr && dm_wstrb != 4'h0)));
            check("BWEB", BWEB, e_bweb);
            check("A",    32'(A), 32'(e_a));
            check("DI",   DI, e_di);
            check("fetch_rsp_v", 32'(fetch_rsp_valid), 32'(m_last == 1 && !fetch_flush));
            check("dm_rsp_v",    32'(dm_rsp_valid),    32'(m_last == 2));
            check("fetch_rsp_data_do", fetch_rsp_data, DO);
            check("dm_rsp_data_do",    dm_rsp_data,    DO);
            if (m_last != 0) check("rsp_data", DO, m_data);
            // advance the model
            m_starve = (f_ok && !gf) ? ((m_starve < STARVE_MAX) ? m_starve + 1 : m_starve) : 0;
            m_last   = gf ? 1 : ((gd && !dm_we) ? 2 : 0);
            m_data   = smem[e_a[7:0]];
            if (wr) begin
                mask = ~e_bweb;
                smem[e_a[7:0]] = (smem[e_a[7:0]] & ~mask) | (dm_wdata & mask);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic fv, input logic [31:0] fa, input logic fl,
                         input logic dv, input logic we, input logic [3:0] st,
                         input logic [31:0] da, input logic [31:0] wd);
        fetch_req_valid = fv;
        fetch_addr      = fa;
        fetch_flush     = fl;
        dm_req_valid    = dv;
        dm_we           = we;
        dm_wstrb        = st;
        dm_addr         = da;
        dm_wdata        = wd;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            sram[i] = {16'hC0DE, 8'h00, 8'(i)};
            smem[i] = {16'hC0DE, 8'h00, 8'(i)};
        end
        sram[4] = 32'hDEAD_BEEF;
        smem[4] = 32'hDEAD_BEEF;
        rst = 1'b0;
        idle();
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        step();

        // fetch-only read of word 4
        step(); drive(1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        #2 check("lit_fetch_ready", 32'(fetch_req_ready), 32'd1);
        check("lit_fetch_A", 32'(A), 32'd4);
        step(); idle();
        #2 check("lit_fetch_rsp_v", 32'(fetch_rsp_valid), 32'd1);
        check("lit_fetch_rsp_data", fetch_rsp_data, 32'hDEAD_BEEF);

        // partial write then read back
        step(); drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 4'b0011, 32'h20, 32'h1234_5678);
        #2 check("lit_wr_WEB", 32'(WEB), 32'd0);
        check("lit_wr_A", 32'(A), 32'd8);
        check("lit_wr_BWEB", BWEB, 32'hFFFF_0000);
        step(); drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 4'h0, 32'h20, 32'h0);
        #2 check("lit_rd_ready", 32'(dm_req_ready), 32'd1);
        step(); idle();
        #2 check("lit_rd_rsp_v", 32'(dm_rsp_valid), 32'd1);
        check("lit_rd_low", 32'(dm_rsp_data[15:0]), 32'h5678);
        check("lit_rd_high", 32'(dm_rsp_data[31:16]), 32'hC0DE);

        // continuous contention: DM,DM,DM,FETCH repeating
        for (int k = 0; k < 12; k++) begin
            step(); drive(1'b1, 32'h40 + 32'(4*k), 1'b0, 1'b1, 1'b0, 4'h0, 32'h80 + 32'(4*k), 32'h0);
            #2 check($sformatf("lit_starve_fetch_%0d", k), 32'(fetch_req_ready), 32'(k % 4 == 3));
            check($sformatf("lit_starve_dm_%0d", k), 32'(dm_req_ready), 32'(k % 4 != 3));
        end
        step(); idle();

        // flush kills the in-flight fetch; dm read in the same cycle is fine
        step(); drive(1'b1, 32'h14, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        #2 check("lit_fl_fetch_ready", 32'(fetch_req_ready), 32'd1);
        step(); drive(1'b1, 32'h18, 1'b1, 1'b1, 1'b0, 4'h0, 32'h24, 32'h0);
        #2 check("lit_fl_rsp_v", 32'(fetch_rsp_valid), 32'd0);
        check("lit_fl_fetch_ready2", 32'(fetch_req_ready), 32'd0);
        check("lit_fl_dm_ready", 32'(dm_req_ready), 32'd1);
        step(); idle();
        #2 check("lit_fl_dm_rsp_v", 32'(dm_rsp_valid), 32'd1);
        check("lit_fl_dm_rsp_data", dm_rsp_data, 32'hC0DE_0009);

        // write with empty strobe: granted, no SRAM write, no response
        step(); drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 4'h0, 32'h30, 32'hFFFF_FFFF);
        #2 check("lit_s0_ready", 32'(dm_req_ready), 32'd1);
        check("lit_s0_WEB", 32'(WEB), 32'd1);
        step(); drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 4'h0, 32'h30, 32'h0);
        #2 check("lit_s0_rsp_v", 32'(dm_rsp_valid), 32'd0);
        step(); idle();
        #2 check("lit_s0_readback", dm_rsp_data, 32'hC0DE_000C);

        // async reset while a fetch response is due
        step(); drive(1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        step(); idle();
        #2 check("lit_ar_rsp_before", 32'(fetch_rsp_valid), 32'd1);
        rst = 1'b0;
        #1 check("lit_ar_rsp_after", 32'(fetch_rsp_valid), 32'd0);
        check("lit_ar_CEB", 32'(CEB), 32'd1);
        step(); step();
        rst = 1'b1;
        step(); step();
        drive(1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        #2 check("lit_post_rst_grant", 32'(fetch_req_ready), 32'd1);
        step(); idle();
        #2 check("lit_post_rst_data", fetch_rsp_data, 32'hDEAD_BEEF);
        step(); step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 3, SHALL set the consecutive fetch-loss cycles after which fetch wins arbitration (range 1..15).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-004 fetch_req_valid  input  1  fetch read request.
REQ-005 fetch_addr  input  32  fetch byte address; bits [15:2] are used.
REQ-006 fetch_flush  input  1  cancels any pending or in-flight fetch.
REQ-007 fetch_req_ready  output  1  fetch request granted this cycle.
REQ-008 fetch_rsp_valid  output  1  fetch_rsp_data valid.
REQ-009 fetch_rsp_data  output  32  fetch read data.
REQ-010 dm_req_valid  input  1  data-memory request.
REQ-011 dm_we  input  1  1 = write, 0 = read.
REQ-012 dm_wstrb  input  4  active-high byte strobes for writes.
REQ-013 dm_addr  input  32  data byte address; bits [15:2] are used.
REQ-014 dm_wdata  input  32  write data.
REQ-015 dm_req_ready  output  1  data request granted this cycle.
REQ-016 dm_rsp_valid  output  1  dm_rsp_data valid (reads only).
REQ-017 dm_rsp_data  output  32  data read data.
REQ-018 CEB  output  1  SRAM chip enable, active-low.
REQ-019 WEB  output  1  SRAM write enable, active-low (1 = read).
REQ-020 BWEB  output  32  SRAM per-bit write enable, active-low.
REQ-021 A  output  14  SRAM word address.
REQ-022 DI  output  32  SRAM write data.
REQ-023 DO  input  32  SRAM read data; valid one cycle after a read is issued.

Function
REQ-024 Grant SHALL be combinational in cycle t: fetch_req_ready or dm_req_ready, never both; the granted access SHALL be driven onto the SRAM port in the same cycle t.
REQ-025 Fetch eligibility SHALL be fetch_req_valid AND NOT fetch_flush.
REQ-026 Only one requester eligible: that requester SHALL be granted.
REQ-027 Both eligible: dm SHALL win unless starve_cnt == STARVE_MAX, in which case fetch SHALL win.
REQ-028 starve_cnt (4-bit): +1 when fetch is eligible but not granted, saturating at STARVE_MAX; cleared to 0 when fetch is granted or fetch is not eligible.
REQ-029 Fetch grant drive: CEB=0, WEB=1, BWEB=all ones, A=fetch_addr[15:2], DI=0.
REQ-030 dm read grant drive: CEB=0, WEB=1, BWEB=all ones, A=dm_addr[15:2], DI=0.
REQ-031 dm write grant drive: CEB=0, WEB=0, A=dm_addr[15:2], DI=dm_wdata; byte i of BWEB SHALL be 8'h00 when dm_wstrb[i]=1 and 8'hFF otherwise.
REQ-032 dm write with dm_wstrb=0 SHALL still be granted but drive WEB=1 (no SRAM write) and produce no response.
REQ-033 No grant: CEB=1, WEB=1, BWEB=all ones, A=0, DI=0.
REQ-034 A registered in-flight tag (NONE/FETCH/DM) SHALL record every read grant; in cycle t+1, the tagged rsp_valid SHALL be 1 for exactly one cycle, with rsp_data=DO.
REQ-035 Writes SHALL set the tag to NONE; completion is signalled only by dm_req_ready.
REQ-036 fetch_flush=1 in cycle t+1 while tag=FETCH SHALL suppress fetch_rsp_valid.
REQ-037 Back-to-back reads SHALL be grantable every cycle (full throughput); responses SHALL return in grant order.
REQ-038 Responses have no backpressure; the requester SHALL accept them.
REQ-039 fetch_rsp_data and dm_rsp_data SHALL both equal DO every cycle; only the valids qualify them.

Reset
REQ-040 While rst=0: fetch_rsp_valid=0, dm_rsp_valid=0, tag=NONE, starve_cnt=0, fetch_req_ready=0, dm_req_ready=0, CEB=1, WEB=1, BWEB=all ones, A=0, DI=0.
REQ-041 Reset asserted mid-operation SHALL drop any in-flight response; after release, the first grant SHALL be possible in the first active cycle.

Verification
REQ-042 Fetch-only read of addr 0x0000_0010 with SRAM word 4 = 0xDEADBEEF -> fetch_req_ready=1 and A=4 in cycle t; fetch_rsp_valid=1 and data 0xDEADBEEF in t+1.
REQ-043 dm write to addr 0x20 with dm_wstrb=4'b0011 and dm_wdata=0x12345678 -> WEB=0, A=8, BWEB=0xFFFF0000; a dm read of 0x20 in the next cycle returns low half 0x5678.
REQ-044 Fetch and dm both valid continuously with STARVE_MAX=3 -> grant pattern DM,DM,DM,FETCH repeating.
REQ-045 Fetch granted in cycle t, then fetch_flush=1 in t+1 -> fetch_rsp_valid stays 0; a dm read granted in t+1 responds normally in t+2.
REQ-046 Fetch granted in cycle t, then rst=0 asynchronously mid-cycle t+1 -> fetch_rsp_valid falls to 0 immediately; after release, outputs match REQ-040 until a new request arrives.
